// File: rtl/hazard_fwd_unit_if.sv
// Bus between the pipeline control path and the hazard/forwarding unit.
// master: pipeline side (drives stage info, observes selects/stall/status).
// slave : hazard_fwd_unit (consumes stage info, drives selects/stall/status).
interface hazard_fwd_unit_if #(
   parameter int unsigned NSRC  = 2,
   parameter int unsigned AW    = 5,
   parameter int unsigned CNT_W = 32
);
   // ID stage
   logic                 id_valid;
   logic [NSRC*AW-1:0]   id_src;
   logic [AW-1:0]        id_rd;
   logic                 id_regwrite;
   logic                 id_is_mc;
   // EX stage
   logic                 ex_valid;
   logic [NSRC*AW-1:0]   ex_src;
   logic [AW-1:0]        ex_rd;
   logic                 ex_regwrite;
   logic                 ex_is_load;
   logic                 ex_is_mc;
   // EX/MEM and MEM/WB writers
   logic [AW-1:0]        mem_rd;
   logic                 mem_regwrite;
   logic [AW-1:0]        wb_rd;
   logic                 wb_regwrite;
   // Results
   logic [NSRC*2-1:0]    fwd_sel;
   logic                 stall_id;
   logic                 mc_busy;
   logic                 mc_done;
   logic [AW-1:0]        mc_rd;
   logic                 mc_ovf;
   logic [CNT_W-1:0]     stall_cnt;

   modport master (
      output id_valid, id_src, id_rd, id_regwrite, id_is_mc,
             ex_valid, ex_src, ex_rd, ex_regwrite, ex_is_load, ex_is_mc,
             mem_rd, mem_regwrite, wb_rd, wb_regwrite,
      input  fwd_sel, stall_id, mc_busy, mc_done, mc_rd, mc_ovf, stall_cnt
   );

   modport slave (
      input  id_valid, id_src, id_rd, id_regwrite, id_is_mc,
             ex_valid, ex_src, ex_rd, ex_regwrite, ex_is_load, ex_is_mc,
             mem_rd, mem_regwrite, wb_rd, wb_regwrite,
      output fwd_sel, stall_id, mc_busy, mc_done, mc_rd, mc_ovf, stall_cnt
   );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and EX operand forwarding for a 5-stage pipeline, with a
// one-entry scoreboard for an outstanding multi-cycle (MDU) op and a
// saturating stall-cycle counter.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - hazard_fwd_unit_if slave: ID/EX/MEM/WB stage info in;
//          fwd_sel, stall_id (combinational) and mc_busy, mc_done, mc_rd,
//          mc_ovf, stall_cnt (from registered state) out
module hazard_fwd_unit #(
   parameter int unsigned NSRC   = 2,
   parameter int unsigned AW     = 5,
   parameter int unsigned MC_LAT = 4,
   parameter int unsigned CNT_W  = 32
) (
   input logic               clk,
   input logic               rst,
   hazard_fwd_unit_if.slave  bus
);

   localparam int unsigned CW = $clog2(MC_LAT + 1);

   logic [CW-1:0]       count_q, count_d;
   logic [AW-1:0]       mc_rd_q, mc_rd_d;
   logic                mc_ovf_q, mc_ovf_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

   logic [NSRC*2-1:0]   fwd_sel_c;
   logic                stall_id_c;
   logic                ex_match, sb_match;
   logic [AW-1:0]       id_s, ex_s;
   logic                mc_capture;

   // Forwarding select per EX operand; EX/MEM wins over MEM/WB, r0 never forwarded
   always_comb begin
      fwd_sel_c = '0;
      ex_s      = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         ex_s = bus.ex_src[i*AW +: AW];
         if (!rst && ex_s != '0) begin
            if (bus.mem_regwrite && bus.mem_rd == ex_s)
               fwd_sel_c[i*2 +: 2] = 2'b10;
            else if (bus.wb_regwrite && bus.wb_rd == ex_s)
               fwd_sel_c[i*2 +: 2] = 2'b01;
         end
      end
   end

   // Source-operand matches against the EX destination and the scoreboard entry
   always_comb begin
      ex_match = 1'b0;
      sb_match = 1'b0;
      id_s     = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         id_s = bus.id_src[i*AW +: AW];
         if (id_s != '0) begin
            if (id_s == bus.ex_rd) ex_match = 1'b1;
            if (id_s == mc_rd_q)   sb_match = 1'b1;
         end
      end
   end

   // Stall: load-use, MC-in-EX RAW, scoreboard RAW, WAW, structural
   always_comb begin
      stall_id_c = 1'b0;
      if (!rst && bus.id_valid) begin
         stall_id_c =
            (bus.ex_valid && bus.ex_is_load && bus.ex_regwrite && ex_match) ||
            (bus.ex_valid && bus.ex_is_mc && ex_match) ||
            ((count_q != '0) && sb_match) ||
            ((count_q != '0) && bus.id_regwrite && (bus.id_rd != '0) &&
             (bus.id_rd == mc_rd_q)) ||
            (bus.id_is_mc && ((count_q != '0) || (bus.ex_valid && bus.ex_is_mc)));
      end
   end

   assign mc_capture = bus.ex_valid && bus.ex_is_mc;

   // Scoreboard and stall counter next state; an overlapping capture is dropped
   // but the running op keeps counting down
   always_comb begin
      count_d     = count_q;
      mc_rd_d     = mc_rd_q;
      mc_ovf_d    = mc_ovf_q;
      stall_cnt_d = stall_cnt_q;
      if (mc_capture && count_q == '0) begin
         count_d = CW'(MC_LAT);
         mc_rd_d = bus.ex_rd;
      end else begin
         if (mc_capture)     mc_ovf_d = 1'b1;
         if (count_q != '0)  count_d  = count_q - CW'(1);
      end
      if (stall_id_c && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= '0;
         mc_rd_q     <= '0;
         mc_ovf_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         count_q     <= count_d;
         mc_rd_q     <= mc_rd_d;
         mc_ovf_q    <= mc_ovf_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.fwd_sel   = fwd_sel_c;
   assign bus.stall_id  = stall_id_c;
   assign bus.mc_busy   = (count_q != '0);
   assign bus.mc_done   = (count_q == CW'(1));
   assign bus.mc_rd     = mc_rd_q;
   assign bus.mc_ovf    = mc_ovf_q;
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: a table of combinational
// forwarding/load-use vectors, then hand-written multi-cycle sequences
// (load-use, MC RAW, WAW/structural, overflow/reset, counter saturation).
module tb_hazard_fwd_unit;

   localparam int unsigned NSRC = 2;
   localparam int unsigned AW   = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_fwd_unit_if #(.NSRC(NSRC), .AW(AW), .CNT_W(32)) h  ();
   hazard_fwd_unit_if #(.NSRC(NSRC), .AW(AW), .CNT_W(4))  h2 ();

   hazard_fwd_unit #(.NSRC(NSRC), .AW(AW), .MC_LAT(4), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (h)
   );

   hazard_fwd_unit #(.NSRC(NSRC), .AW(AW), .MC_LAT(4), .CNT_W(4)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (h2)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0] es0, es1, mrd, wrd, ids0, ids1, exrd;
      logic       mrw, wrw, idv, exv, exld, exrw, idmc;
      logic [3:0] exp_fwd;
      logic       exp_stall;
   } vec_t;

   vec_t vecs [12];

   function automatic vec_t mkv(
      input logic [4:0] es0, input logic [4:0] es1,
      input logic [4:0] mrd, input logic mrw,
      input logic [4:0] wrd, input logic wrw,
      input logic idv, input logic [4:0] ids0, input logic [4:0] ids1,
      input logic exv, input logic exld, input logic exrw, input logic [4:0] exrd,
      input logic idmc, input logic [3:0] ef, input logic es);
      vec_t v;
      v.es0 = es0; v.es1 = es1; v.mrd = mrd; v.mrw = mrw; v.wrd = wrd; v.wrw = wrw;
      v.idv = idv; v.ids0 = ids0; v.ids1 = ids1; v.exv = exv; v.exld = exld;
      v.exrw = exrw; v.exrd = exrd; v.idmc = idmc; v.exp_fwd = ef; v.exp_stall = es;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      h.id_valid = 0; h.id_src = '0; h.id_rd = '0; h.id_regwrite = 0; h.id_is_mc = 0;
      h.ex_valid = 0; h.ex_src = '0; h.ex_rd = '0; h.ex_regwrite = 0;
      h.ex_is_load = 0; h.ex_is_mc = 0;
      h.mem_rd = '0; h.mem_regwrite = 0; h.wb_rd = '0; h.wb_regwrite = 0;
      h2.id_valid = 0; h2.id_src = '0; h2.id_rd = '0; h2.id_regwrite = 0; h2.id_is_mc = 0;
      h2.ex_valid = 0; h2.ex_src = '0; h2.ex_rd = '0; h2.ex_regwrite = 0;
      h2.ex_is_load = 0; h2.ex_is_mc = 0;
      h2.mem_rd = '0; h2.mem_regwrite = 0; h2.wb_rd = '0; h2.wb_regwrite = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic mc_capture(input logic [4:0] rd);
      h.ex_valid = 1; h.ex_is_mc = 1; h.ex_rd = rd; h.ex_regwrite = 1;
      tick();
      h.ex_valid = 0; h.ex_is_mc = 0; h.ex_rd = '0; h.ex_regwrite = 0;
   endtask

   initial begin
      vecs[0]  = mkv(5, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0);
      vecs[1]  = mkv(5, 0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0);
      vecs[2]  = mkv(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
      vecs[3]  = mkv(3, 6, 3, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0110, 0);
      vecs[4]  = mkv(5, 5, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
      vecs[5]  = mkv(0, 0, 0, 0, 0, 0, 1, 0, 7, 1, 1, 1, 7, 0, 4'b0000, 1);
      vecs[6]  = mkv(0, 0, 0, 0, 0, 0, 1, 0, 7, 1, 1, 0, 7, 0, 4'b0000, 0);
      vecs[7]  = mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 4'b0000, 0);
      vecs[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 1, 1, 7, 0, 4'b0000, 0);
      vecs[9]  = mkv(0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 1, 1, 7, 0, 4'b0000, 1);
      vecs[10] = mkv(0, 0, 0, 0, 0, 0, 1, 3, 4, 0, 0, 0, 0, 1, 4'b0000, 0);
      vecs[11] = mkv(0, 7, 7, 1, 0, 0, 1, 0, 7, 1, 1, 1, 7, 0, 4'b1000, 1);

      clear_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
      #2;
      chk("rst_busy",      32'(h.mc_busy),   0);
      chk("rst_done",      32'(h.mc_done),   0);
      chk("rst_mc_rd",     32'(h.mc_rd),     0);
      chk("rst_ovf",       32'(h.mc_ovf),    0);
      chk("rst_stall_cnt", h.stall_cnt,      0);
      chk("rst_fwd",       32'(h.fwd_sel),   0);
      chk("rst_stall",     32'(h.stall_id),  0);

      // Combinational vectors
      for (int k = 0; k < 12; k++) begin
         h.ex_src      = {vecs[k].es1, vecs[k].es0};
         h.mem_rd      = vecs[k].mrd;  h.mem_regwrite = vecs[k].mrw;
         h.wb_rd       = vecs[k].wrd;  h.wb_regwrite  = vecs[k].wrw;
         h.id_valid    = vecs[k].idv;
         h.id_src      = {vecs[k].ids1, vecs[k].ids0};
         h.ex_valid    = vecs[k].exv;  h.ex_is_load   = vecs[k].exld;
         h.ex_regwrite = vecs[k].exrw; h.ex_rd        = vecs[k].exrd;
         h.id_is_mc    = vecs[k].idmc;
         #2;
         chk($sformatf("vec%0d_fwd", k),   32'(h.fwd_sel),  32'(vecs[k].exp_fwd));
         chk($sformatf("vec%0d_stall", k), 32'(h.stall_id), 32'(vecs[k].exp_stall));
         tick();
      end

      // Load-use: one stall cycle, then EX/MEM forwarding of the load result
      do_reset();
      h.ex_valid = 1; h.ex_is_load = 1; h.ex_regwrite = 1; h.ex_rd = 7;
      h.id_valid = 1; h.id_src = {5'd7, 5'd2};
      #2;
      chk("lu_stall", 32'(h.stall_id), 1);
      tick();
      h.ex_valid = 0; h.ex_is_load = 0; h.ex_regwrite = 0; h.ex_rd = '0;
      h.mem_rd = 7; h.mem_regwrite = 1;
      h.ex_src = {5'd7, 5'd2};
      #2;
      chk("lu_stall_after", 32'(h.stall_id), 0);
      chk("lu_fwd",         32'(h.fwd_sel),  32'(4'b1000));
      chk("lu_stall_cnt",   h.stall_cnt,     1);

      // MC RAW: EX term at cycle 0, scoreboard through mc_done, release at cycle 5
      do_reset();
      h.ex_valid = 1; h.ex_is_mc = 1; h.ex_regwrite = 1; h.ex_rd = 9;
      h.id_valid = 1; h.id_src = {5'd0, 5'd9};
      #2;
      chk("mc_c0_stall", 32'(h.stall_id), 1);
      chk("mc_c0_busy",  32'(h.mc_busy),  0);
      tick();
      h.ex_valid = 0; h.ex_is_mc = 0; h.ex_regwrite = 0; h.ex_rd = '0;
      for (int c = 1; c <= 4; c++) begin
         #2;
         chk($sformatf("mc_c%0d_stall", c), 32'(h.stall_id), 1);
         chk($sformatf("mc_c%0d_busy", c),  32'(h.mc_busy),  1);
         chk($sformatf("mc_c%0d_done", c),  32'(h.mc_done),  (c == 4) ? 32'd1 : 32'd0);
         chk($sformatf("mc_c%0d_rd", c),    32'(h.mc_rd),    9);
         tick();
      end
      #2;
      chk("mc_c5_stall", 32'(h.stall_id), 0);
      chk("mc_c5_busy",  32'(h.mc_busy),  0);
      chk("mc_c5_cnt",   h.stall_cnt,     5);

      // WAW, structural, unrelated instruction
      do_reset();
      mc_capture(9);
      h.id_valid = 1; h.id_src = {5'd4, 5'd3}; h.id_rd = 9; h.id_regwrite = 1;
      #2;
      chk("waw_stall", 32'(h.stall_id), 1);
      h.id_rd = 6; h.id_is_mc = 1;
      #1;
      chk("struct_stall", 32'(h.stall_id), 1);
      h.id_is_mc = 0;
      #1;
      chk("unrel_stall", 32'(h.stall_id), 0);
      h.id_is_mc = 1;
      tick();
      begin
         int guard = 0;
         while (h.mc_busy && guard < 10) begin
            #1;
            chk("struct_hold", 32'(h.stall_id), 1);
            tick();
            guard++;
         end
         chk("struct_busy_bound", 32'(guard), 3);
      end
      #1;
      chk("struct_release", 32'(h.stall_id), 0);

      // Overflow: second capture while count==2 is dropped, count runs on
      do_reset();
      mc_capture(9);          // count 4
      tick();                 // count 3
      tick();                 // count 2
      h.ex_valid = 1; h.ex_is_mc = 1; h.ex_rd = 12; h.ex_regwrite = 1;
      tick();                 // count 1
      h.ex_valid = 0; h.ex_is_mc = 0; h.ex_rd = '0; h.ex_regwrite = 0;
      #1;
      chk("ovf_flag",  32'(h.mc_ovf),  1);
      chk("ovf_done",  32'(h.mc_done), 1);
      chk("ovf_mc_rd", 32'(h.mc_rd),   9);
      tick();                 // count 0
      #1;
      chk("ovf_busy_end", 32'(h.mc_busy), 0);
      chk("ovf_sticky",   32'(h.mc_ovf),  1);

      // Reset with count==3 cancels the op without an mc_done pulse
      mc_capture(10);         // count 4
      h.id_valid = 1; h.id_src = {5'd0, 5'd10};
      tick();                 // count 3
      #1;
      chk("pre_rst_stall", 32'(h.stall_id), 1);
      rst = 1;
      h.ex_src = {5'd0, 5'd5}; h.mem_rd = 5; h.mem_regwrite = 1;
      #1;
      chk("in_rst_stall", 32'(h.stall_id), 0);
      chk("in_rst_fwd",   32'(h.fwd_sel),  0);
      tick();
      rst = 0;
      clear_inputs();
      #1;
      chk("post_rst_busy", 32'(h.mc_busy),   0);
      chk("post_rst_ovf",  32'(h.mc_ovf),    0);
      chk("post_rst_cnt",  h.stall_cnt,      0);
      begin
         int done_seen = 0;
         for (int c = 0; c < 5; c++) begin
            if (h.mc_done) done_seen++;
            tick();
         end
         chk("post_rst_no_done", 32'(done_seen), 0);
      end

      // Saturation of a 4-bit stall counter under a held load-use stall
      do_reset();
      h2.id_valid = 1; h2.id_src = {5'd0, 5'd7};
      h2.ex_valid = 1; h2.ex_is_load = 1; h2.ex_regwrite = 1; h2.ex_rd = 7;
      for (int c = 0; c < 20; c++) begin
         if (c == 14) chk("sat_cnt_14", h2.stall_cnt, 14);
         tick();
      end
      #1;
      chk("sat_cnt_20", h2.stall_cnt, 15);
      clear_inputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
